// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Writer side of the instruction store. Takes a byte stream over a valid/ready
// handshake, packs the bytes little-endian into DATA_WIDTH words and writes
// them to consecutive instruction-memory addresses starting at 0. The CPU is
// held in reset for the whole load and released once the last word is
// written, at which point a running word checksum is available.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      one-cycle pulse, begins or restarts a load
//   length     number of words to load (sampled on start, clamped to depth)
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle (high only while loading)
//   mem_we     one-cycle write strobe to instruction memory
//   mem_addr   write address (holds last written address afterwards)
//   mem_data   write data
//   cpu_reset  high holds the CPU in reset
//   busy       high while loading
//   done       high once the load has completed
//   checksum   modulo-2^DATA_WIDTH sum of the words written in this load
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                  state_reg,    state_next;
    logic [IDX_W-1:0]        byte_idx_reg, byte_idx_next;
    logic [DATA_WIDTH-1:0]   shift_reg,    shift_next;
    logic [ADDR_WIDTH:0]     word_cnt_reg, word_cnt_next;
    logic [ADDR_WIDTH:0]     len_reg,      len_next;
    logic                    mem_we_reg,   mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_data_reg, mem_data_next;
    logic [DATA_WIDTH-1:0]   checksum_reg, checksum_next;

    logic                    accept;
    logic [ADDR_WIDTH:0]     len_clamped;
    logic [DATA_WIDTH-1:0]   word_assembled;

    assign accept      = in_valid && (state_reg == S_LOAD);
    assign len_clamped = (length > DEPTH) ? DEPTH : length;

    // The word as it looks with the incoming byte dropped into its lane.
    // Lanes not addressed by byte_idx keep what is already in the register.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign word_assembled[8*gi +: 8] =
            (byte_idx_reg == IDX_W'(gi)) ? in_data : shift_reg[8*gi +: 8];
    end

    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        shift_next    = shift_reg;
        word_cnt_next = word_cnt_reg;
        len_next      = len_reg;
        mem_we_next   = 1'b0;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;
        checksum_next = checksum_reg;

        case (state_reg)
            S_LOAD: begin
                if (accept) begin
                    shift_next = word_assembled;
                    if (byte_idx_reg == LAST_IDX) begin
                        byte_idx_next = '0;
                        // Bytes arriving after the final word (while its write
                        // strobe is still out) must never produce a write.
                        if (word_cnt_reg < len_reg) begin
                            mem_we_next   = 1'b1;
                            mem_addr_next = word_cnt_reg[ADDR_WIDTH-1:0];
                            mem_data_next = word_assembled;
                            checksum_next = checksum_reg + word_assembled;
                            word_cnt_next = word_cnt_reg + (ADDR_WIDTH+1)'(1);
                        end
                    end else begin
                        byte_idx_next = byte_idx_reg + IDX_W'(1);
                    end
                end
                // Leave LOAD the cycle after the final write strobe.
                if (mem_we_reg && (word_cnt_reg == len_reg)) begin
                    state_next = S_DONE;
                end
            end
            default: ;
        endcase

        // start wins over everything, including a byte taken this cycle.
        if (start) begin
            len_next      = len_clamped;
            byte_idx_next = '0;
            shift_next    = '0;
            word_cnt_next = '0;
            mem_we_next   = 1'b0;
            mem_addr_next = '0;
            checksum_next = '0;
            state_next    = (len_clamped == '0) ? S_DONE : S_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            byte_idx_reg <= '0;
            shift_reg    <= '0;
            word_cnt_reg <= '0;
            len_reg      <= '0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            checksum_reg <= '0;
        end else begin
            state_reg    <= state_next;
            byte_idx_reg <= byte_idx_next;
            shift_reg    <= shift_next;
            word_cnt_reg <= word_cnt_next;
            len_reg      <= len_next;
            mem_we_reg   <= mem_we_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
            checksum_reg <= checksum_next;
        end
    end

    // Status outputs follow the state directly so they change on the same
    // edge as the state transition.
    assign in_ready  = (state_reg == S_LOAD);
    assign busy      = (state_reg == S_LOAD);
    assign done      = (state_reg == S_DONE);
    assign cpu_reset = (state_reg != S_DONE);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_data  = mem_data_reg;
    assign checksum  = checksum_reg;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the 256 x 32 instruction store interface.
- Accepts a byte stream (e.g. from a UART receiver) through a valid/ready handshake.
- Assembles bytes little-endian into DATA_WIDTH words and writes them to sequential instruction-memory addresses starting at 0.
- Holds the CPU in reset for the whole load, then releases it and reports a word checksum.

Parameters:
ADDR_WIDTH, 8, instruction memory address width (depth 2^ADDR_WIDTH words).
DATA_WIDTH, 32, word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins (or restarts) a load.
length  input  ADDR_WIDTH+1  number of words to load; sampled on start.
in_data  input  8  stream byte.
in_valid  input  1  in_data valid.
in_ready  output  1  loader accepts byte this cycle.
mem_we  output  1  one-cycle write strobe to instruction memory.
mem_addr  output  ADDR_WIDTH  write address.
mem_data  output  DATA_WIDTH  write data.
cpu_reset  output  1  high holds the CPU in reset.
busy  output  1  high while in LOAD.
done  output  1  high in DONE.
checksum  output  DATA_WIDTH  modulo-2^DATA_WIDTH sum of all words written in the current load.

Behaviour:
- Reset (async): state=IDLE; in_ready=0; mem_we=0; mem_addr=0; mem_data=0; cpu_reset=1; busy=0; done=0; checksum=0; internal byte index=0; word counter=0.
- States: IDLE, LOAD, DONE.
- start in any state (incl. mid-LOAD or DONE) does all of the following:
  - Sample length; values > 2^ADDR_WIDTH clamp to 2^ADDR_WIDTH.
  - Clear byte index, word counter, write address and checksum.
  - Assert cpu_reset=1 and drop done.
  - Go to LOAD if clamped length != 0; otherwise go directly to DONE.
- start has priority over a byte accepted in the same cycle; that byte is discarded.
- LOAD:
  - in_ready=1 combinationally while in LOAD (no stall cycles).
  - A byte is accepted when in_valid && in_ready.
  - Byte k (k=0..BYTES-1) goes into bits [8k+7:8k] of the word shift register.
  - On acceptance of byte BYTES-1, in the next cycle: mem_we=1 for exactly one cycle, mem_addr = word counter, mem_data = assembled word. Checksum updates in that same cycle. Word counter increments.
  - Partial bytes persist across in_valid gaps of any length.
- After the write of word number length-1: state=DONE in the cycle following that mem_we.
  - Transition timing: the cycle following that mem_we.
  - Outputs on entering DONE: cpu_reset=0, done=1, busy=0.
  - mem_addr holds the last written address.
- DONE: in_ready=0; bytes ignored; outputs stable until start or reset.
- IDLE: in_ready=0; bytes ignored; cpu_reset=1.
- mem_addr wraps naturally; with clamping, the highest address written is 2^ADDR_WIDTH-1.
- Reset asserted mid-load aborts immediately to reset values; memory contents already written are not altered.
- Latency: last byte of a word accepted on cycle N -> mem_we on cycle N+1.

Test Plan:
- Reset values: assert reset mid-cycle -> all outputs at reset values immediately, cpu_reset=1, in_ready=0.
- Basic load: start with length=2, then bytes 01 00 00 00 03 00 00 00 back-to-back.
  - Expect writes addr0=0x00000001 and addr1=0x00000003.
  - Expect checksum=0x00000004, done=1, cpu_reset=0 one cycle after the second mem_we.
- Gapped stream: the same bytes with random in_valid gaps (0-5 cycles) -> identical writes and checksum; exactly 2 mem_we pulses.
- Zero length: start with length=0 -> DONE next cycle, no mem_we, checksum=0.
- Restart: start mid-load after 6 bytes, then length=1 and bytes 03 40 00 08.
  - Expect a single write addr0=0x08004003.
  - The earlier partial word is never written.
- Full depth with clamp: length=300 and 1024 bytes of pattern word i = i.
  - Expect 256 writes, addr 0..255, data 0..255.
  - Expect checksum=0x00007F80, done after the 256th write; further bytes are not accepted.
